fma_read_buffer: RTL and testbench
==================================

FMA_READ_BUFFER -- requirements
Module: fma_read_buffer

Interface
REQ-001 The block SHALL have parameter FMA_COUNT, default 2, meaning the number of FMA lanes fed per line.
REQ-002 The block SHALL have parameter WORD_WIDTH, default 16, meaning the bits per word.
REQ-003 The block SHALL have parameter LINE_WIDTH, default 96, meaning FMA_COUNT*3*WORD_WIDTH.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning the number of line entries; it SHALL be a power of two and at least 2.
REQ-005 The block SHALL have port clk_in, input, 1 bit, the single clock.
REQ-006 The block SHALL have port rst_in, input, 1 bit, the reset, asynchronous and active-high.
REQ-007 The block SHALL have port abc_in, input, LINE_WIDTH bits, the line from the memory stage; word k occupies bits [LINE_WIDTH-(k+1)*WORD_WIDTH +: WORD_WIDTH].
REQ-008 The block SHALL have port abc_valid_in, input, 1 bit, a single-cycle strobe qualifying abc_in; there is no backpressure toward memory.
REQ-009 The block SHALL have port flush_in, input, 1 bit, a synchronous discard of all entries.
REQ-010 The block SHALL have ports a_out, b_out and c_out, output, FMA_COUNT*WORD_WIDTH bits each, with lane i at [i*WORD_WIDTH +: WORD_WIDTH].
REQ-011 The block SHALL have port fma_valid_out, output, 1 bit, meaning the head line is presented on a/b/c_out.
REQ-012 The block SHALL have port fma_ready_in, input, 1 bit, the AND of all lane readies; all lanes consume in lockstep.
REQ-013 The block SHALL have port count_out, output, $clog2(DEPTH+1) bits, the current occupancy.
REQ-014 The block SHALL have ports empty_out and full_out, output, 1 bit each, occupancy flags.
REQ-015 The block SHALL have port overflow_out, output, 1 bit, a sticky flag for a dropped line.

Function
REQ-016 Lane i SHALL take word 3i as a, word 3i+1 as b, and word 3i+2 as c.
REQ-017 A push SHALL occur when abc_valid_in=1 and either (count<DEPTH) or (a pop occurs in the same cycle); the line is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
REQ-018 A pop SHALL occur when fma_valid_out=1 and fma_ready_in=1; rd_ptr increments, wrapping modulo DEPTH.
REQ-019 fma_valid_out SHALL equal (count!=0); a/b/c_out SHALL be driven from the entry at rd_ptr with no added register stage.
REQ-020 Latency: a line pushed at edge N SHALL be visible, with fma_valid_out=1, in the cycle after edge N when the buffer was empty before the push.
REQ-021 On a simultaneous push and pop, count SHALL be unchanged, including at count=DEPTH and at count=1.
REQ-022 When abc_valid_in=1, count=DEPTH and no pop occurs, the line SHALL be dropped, the contents SHALL be unchanged, and overflow_out SHALL be set to 1 and held until reset.
REQ-023 The outputs a/b/c_out SHALL hold stable while fma_valid_out=1 and fma_ready_in=0.
REQ-024 flush_in=1 SHALL set wr_ptr, rd_ptr and count to 0 at the next edge.
REQ-025 flush_in SHALL take priority over a push or pop in the same cycle.
REQ-026 flush_in SHALL NOT clear overflow_out.
REQ-027 empty_out SHALL equal (count==0).
REQ-028 full_out SHALL equal (count==DEPTH).
REQ-029 When empty, a/b/c_out SHALL be don't-care; benches SHALL check them only when fma_valid_out=1.

Reset
REQ-030 Asserting rst_in SHALL immediately, without a clock edge, force wr_ptr=0, rd_ptr=0, count_out=0, fma_valid_out=0, empty_out=1, full_out=0 and overflow_out=0.
REQ-031 Reset SHALL NOT be required to clear the storage array.
REQ-032 Reset asserted mid-transfer SHALL discard all entries.
REQ-033 The first push SHALL be accepted at the first rising edge after rst_in deasserts.

Structure
REQ-034 FMA_COUNT, WORD_WIDTH and LINE_WIDTH SHALL live in a shared package gpu_pkg used by memory and the FMA blocks, with a derived constant WORDS_PER_LINE=FMA_COUNT*3.
REQ-035 Storage, pointers and count SHALL be a sub-module line_fifo (WIDTH, DEPTH), with fma_read_buffer providing the lane unpacking, the overflow flag and flush.

Verification
REQ-036 Reset, then push line 0x0001_0002_0003_0004_0005_0006: the next cycle SHALL show fma_valid_out=1, a_out={0x0004,0x0001}, b_out={0x0005,0x0002}, c_out={0x0006,0x0003}, and count_out=1.
REQ-037 Push 4 distinct lines with fma_ready_in=0: full_out=1 and count_out=4; a fifth push SHALL give overflow_out=1 and count_out=4, and draining SHALL return the first 4 lines in order.
REQ-038 At count=4, push and ready in the same cycle: count_out SHALL stay 4, overflow_out SHALL stay 0, and the 4th pop SHALL return the new line.
REQ-039 Perform 10 push/pop pairs of 1 line each: the pointers SHALL wrap, the data SHALL match in order, and empty_out=1 at the end.
REQ-040 With 3 entries, assert flush_in together with abc_valid_in and fma_ready_in: the next cycle SHALL have count_out=0, empty_out=1 and fma_valid_out=0.
REQ-041 Assert rst_in asynchronously mid-stream with 2 entries: the outputs SHALL reach their reset values before the next edge, and overflow_out SHALL be cleared.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU datapath constants used by the memory stage, the read buffer and
// the FMA lanes.
// Ports: none (package).
package gpu_pkg;

    localparam int unsigned FMA_COUNT      = 2;
    localparam int unsigned WORD_WIDTH     = 16;
    localparam int unsigned WORDS_PER_LINE = FMA_COUNT * 3;
    localparam int unsigned LINE_WIDTH     = WORDS_PER_LINE * WORD_WIDTH;
    localparam int unsigned READ_BUF_DEPTH = 4;

    // LSB position of word k inside a line; word 0 is the most significant word.
    function automatic int unsigned word_lsb(input int unsigned line_w,
                                             input int unsigned word_w,
                                             input int unsigned k);
        return line_w - (k + 1) * word_w;
    endfunction

endpackage

// File: rtl/fma_read_buffer_if.sv
// Bus between the memory stage / FMA lanes and the FMA read buffer.
// Signals:
//   abc_in, abc_valid_in    line from memory and its single-cycle strobe
//   flush_in                synchronous discard of all buffered lines
//   a_out, b_out, c_out     per-lane operands of the head line
//   fma_valid_out           head line is presented
//   fma_ready_in            all FMA lanes ready (lockstep consume)
//   count_out, empty_out,
//   full_out, overflow_out  occupancy and sticky drop status
// Modports: master = memory/FMA side, slave = the buffer.
interface fma_read_buffer_if #(
    parameter int unsigned FMA_COUNT  = gpu_pkg::FMA_COUNT,
    parameter int unsigned WORD_WIDTH = gpu_pkg::WORD_WIDTH,
    parameter int unsigned LINE_WIDTH = FMA_COUNT * 3 * WORD_WIDTH,
    parameter int unsigned DEPTH      = gpu_pkg::READ_BUF_DEPTH
);

    localparam int unsigned LANE_WIDTH = FMA_COUNT * WORD_WIDTH;
    localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1);

    logic [LINE_WIDTH-1:0] abc_in;
    logic                  abc_valid_in;
    logic                  flush_in;
    logic [LANE_WIDTH-1:0] a_out;
    logic [LANE_WIDTH-1:0] b_out;
    logic [LANE_WIDTH-1:0] c_out;
    logic                  fma_valid_out;
    logic                  fma_ready_in;
    logic [CNT_WIDTH-1:0]  count_out;
    logic                  empty_out;
    logic                  full_out;
    logic                  overflow_out;

    modport master (
        output abc_in, abc_valid_in, flush_in, fma_ready_in,
        input  a_out, b_out, c_out, fma_valid_out,
               count_out, empty_out, full_out, overflow_out
    );

    modport slave (
        input  abc_in, abc_valid_in, flush_in, fma_ready_in,
        output a_out, b_out, c_out, fma_valid_out,
               count_out, empty_out, full_out, overflow_out
    );

endinterface

// File: rtl/line_fifo.sv
// Circular line storage with read/write pointers and occupancy count.
// The head entry is presented combinationally (show-ahead); a write is
// accepted when there is room or when a read frees a slot in the same cycle.
// Ports:
//   clk_in, rst_in (async, active-high), flush_in (sync discard)
//   wr_valid_in, wr_data_in      write request
//   rd_ready_in                  consumer ready
//   rd_valid_c, rd_data_c        head entry (combinational)
//   push_c, pop_c                accepted write / read this cycle
//   count_out, empty_out, full_out occupancy
module line_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       flush_in,
    input  logic                       wr_valid_in,
    input  logic [WIDTH-1:0]           wr_data_in,
    input  logic                       rd_ready_in,
    output logic                       rd_valid_c,
    output logic [WIDTH-1:0]           rd_data_c,
    output logic                       push_c,
    output logic                       pop_c,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic                       empty_out,
    output logic                       full_out
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign rd_valid_c = (count != '0);
    assign pop_c      = rd_valid_c & rd_ready_in;
    // A full buffer still accepts a line when the head leaves in the same cycle.
    assign push_c     = wr_valid_in & ((count != CNT_MAX) | pop_c);
    assign rd_data_c  = mem[rd_ptr];
    assign count_out  = count;
    assign empty_out  = (count == '0);
    assign full_out   = (count == CNT_MAX);

    // Pointer and occupancy update; flush wins over push/pop.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_c && !pop_c)      count <= count + CNT_W'(1);
            else if (pop_c && !push_c) count <= count - CNT_W'(1);
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk_in) begin
        if (push_c && !flush_in) mem[wr_ptr] <= wr_data_in;
    end

endmodule

// File: rtl/fma_read_buffer.sv
// Read buffer between the memory stage and the FMA lanes. Buffers whole
// lines, unpacks the head line into per-lane a/b/c operands and records a
// sticky overflow when a line arrives with no room for it.
// Ports:
//   clk_in   clock
//   rst_in   asynchronous active-high reset
//   bus      fma_read_buffer_if.slave (line input, lane outputs, status)
module fma_read_buffer #(
    parameter int unsigned FMA_COUNT  = gpu_pkg::FMA_COUNT,
    parameter int unsigned WORD_WIDTH = gpu_pkg::WORD_WIDTH,
    parameter int unsigned LINE_WIDTH = FMA_COUNT * 3 * WORD_WIDTH,
    parameter int unsigned DEPTH      = gpu_pkg::READ_BUF_DEPTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    fma_read_buffer_if.slave bus
);

    localparam int unsigned LANE_WIDTH = FMA_COUNT * WORD_WIDTH;

    logic [LINE_WIDTH-1:0] head_c;
    logic [LANE_WIDTH-1:0] a_c;
    logic [LANE_WIDTH-1:0] b_c;
    logic [LANE_WIDTH-1:0] c_c;
    logic                  head_valid_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  full_c;
    logic                  drop_c;
    logic                  overflow;

    line_fifo #(
        .WIDTH (LINE_WIDTH),
        .DEPTH (DEPTH)
    ) u_line_fifo (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .flush_in    (bus.flush_in),
        .wr_valid_in (bus.abc_valid_in),
        .wr_data_in  (bus.abc_in),
        .rd_ready_in (bus.fma_ready_in),
        .rd_valid_c  (head_valid_c),
        .rd_data_c   (head_c),
        .push_c      (push_c),
        .pop_c       (pop_c),
        .count_out   (bus.count_out),
        .empty_out   (bus.empty_out),
        .full_out    (full_c)
    );

    // Lane g takes words 3g, 3g+1, 3g+2 as a, b, c.
    for (genvar g = 0; g < FMA_COUNT; g++) begin : g_lane
        localparam int unsigned A_LSB = gpu_pkg::word_lsb(LINE_WIDTH, WORD_WIDTH, 3 * g);
        localparam int unsigned B_LSB = gpu_pkg::word_lsb(LINE_WIDTH, WORD_WIDTH, 3 * g + 1);
        localparam int unsigned C_LSB = gpu_pkg::word_lsb(LINE_WIDTH, WORD_WIDTH, 3 * g + 2);
        assign a_c[g*WORD_WIDTH +: WORD_WIDTH] = head_c[A_LSB +: WORD_WIDTH];
        assign b_c[g*WORD_WIDTH +: WORD_WIDTH] = head_c[B_LSB +: WORD_WIDTH];
        assign c_c[g*WORD_WIDTH +: WORD_WIDTH] = head_c[C_LSB +: WORD_WIDTH];
    end

    // A strobed line that the fifo did not take is lost; memory cannot stall.
    assign drop_c = bus.abc_valid_in & ~push_c;

    // Sticky overflow; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)      overflow <= 1'b0;
        else if (drop_c) overflow <= 1'b1;
    end

    assign bus.a_out         = a_c;
    assign bus.b_out         = b_c;
    assign bus.c_out         = c_c;
    assign bus.fma_valid_out = head_valid_c;
    assign bus.full_out      = full_c;
    assign bus.overflow_out  = overflow;

    // pop_c is consumed inside the fifo; kept visible here for debug probes.
    logic unused_pop;
    assign unused_pop = pop_c;

endmodule

// File: tb/tb_fma_read_buffer.sv
// Scoreboard bench for fma_read_buffer: a queue-based occupancy model collects
// accepted lines, a negedge monitor compares status every cycle and pops the
// expected head whenever the DUT hands a line to the lanes.
module tb_fma_read_buffer;

    localparam int unsigned FMA_COUNT  = 2;
    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned LINE_WIDTH = FMA_COUNT * 3 * WORD_WIDTH;
    localparam int unsigned LANE_WIDTH = FMA_COUNT * WORD_WIDTH;
    localparam int unsigned DEPTH      = 4;

    typedef logic [LINE_WIDTH-1:0] line_t;
    typedef logic [LANE_WIDTH-1:0] lane_t;

    logic  clk_in = 1'b0;
    logic  rst_in = 1'b0;
    int    checks = 0;
    int    failures = 0;

    line_t exp_q[$];
    int    mdl_cnt = 0;
    bit    mdl_ovf = 1'b0;
    bit    mdl_pop;
    bit    mdl_room;

    line_t lines[DEPTH];
    line_t new_line;
    line_t tmp_line;

    fma_read_buffer_if #(
        .FMA_COUNT (FMA_COUNT), .WORD_WIDTH (WORD_WIDTH),
        .LINE_WIDTH (LINE_WIDTH), .DEPTH (DEPTH)
    ) bus ();

    fma_read_buffer #(
        .FMA_COUNT (FMA_COUNT), .WORD_WIDTH (WORD_WIDTH),
        .LINE_WIDTH (LINE_WIDTH), .DEPTH (DEPTH)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Operand sel (0=a,1=b,2=c) of every lane, treating the line as a word list
    // whose first word is the most significant one.
    function automatic lane_t lanes(input line_t line, input int sel);
        lane_t r;
        line_t t;
        r = '0;
        for (int i = 0; i < int'(FMA_COUNT); i++) begin
            t = line >> ((3 * FMA_COUNT - 1 - (3 * i + sel)) * WORD_WIDTH);
            r[i*WORD_WIDTH +: WORD_WIDTH] = t[WORD_WIDTH-1:0];
        end
        return r;
    endfunction

    function automatic line_t rnd_line();
        line_t l;
        l = '0;
        for (int i = 0; i < int'(LINE_WIDTH); i += 32) l = (l << 32) | line_t'($urandom());
        return l;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input bit v, input line_t l, input bit r, input bit f);
        bus.abc_valid_in = v;
        bus.abc_in       = l;
        bus.fma_ready_in = r;
        bus.flush_in     = f;
        @(posedge clk_in);
        #1;
    endtask

    // Reference model: occupancy count plus the queue of expected lines.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            exp_q.delete();
            mdl_cnt = 0;
            mdl_ovf = 1'b0;
        end else begin
            mdl_pop  = (mdl_cnt != 0) && bus.fma_ready_in;
            mdl_room = (mdl_cnt < int'(DEPTH));
            if (bus.abc_valid_in && !mdl_room && !mdl_pop) mdl_ovf = 1'b1;
            if (bus.flush_in) begin
                exp_q.delete();
                mdl_cnt = 0;
            end else begin
                if (mdl_pop) mdl_cnt--;
                if (bus.abc_valid_in && (mdl_room || mdl_pop)) begin
                    exp_q.push_back(bus.abc_in);
                    mdl_cnt++;
                end
            end
        end
    end

    // Monitor: status every cycle, data whenever a line is presented.
    always @(negedge clk_in) begin
        check("count", bus.count_out, mdl_cnt);
        check("valid", bus.fma_valid_out, mdl_cnt != 0);
        check("empty", bus.empty_out, mdl_cnt == 0);
        check("full", bus.full_out, mdl_cnt == int'(DEPTH));
        check("overflow", bus.overflow_out, mdl_ovf);
        if (bus.fma_valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL head_present actual=valid required=no_line_expected at %0t", $time);
            end else begin
                check("a_out", bus.a_out, lanes(exp_q[0], 0));
                check("b_out", bus.b_out, lanes(exp_q[0], 1));
                check("c_out", bus.c_out, lanes(exp_q[0], 2));
                if (bus.fma_ready_in) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.abc_valid_in = 1'b0;
        bus.abc_in       = '0;
        bus.fma_ready_in = 1'b0;
        bus.flush_in     = 1'b0;

        // Async reset before any clock edge.
        #1 rst_in = 1'b1;
        #1;
        check("rst_count", bus.count_out, 0);
        check("rst_valid", bus.fma_valid_out, 0);
        check("rst_empty", bus.empty_out, 1);
        check("rst_full", bus.full_out, 0);
        check("rst_overflow", bus.overflow_out, 0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // First push right after reset; visible the next cycle.
        cyc(1'b1, 96'h0001_0002_0003_0004_0005_0006, 1'b0, 1'b0);
        check("first_valid", bus.fma_valid_out, 1);
        check("first_a", bus.a_out, 32'h0004_0001);
        check("first_b", bus.b_out, 32'h0005_0002);
        check("first_c", bus.c_out, 32'h0006_0003);
        check("first_count", bus.count_out, 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("first_drain_empty", bus.empty_out, 1);

        // Fill, overflow, drain in order.
        for (int i = 0; i < int'(DEPTH); i++) begin
            lines[i] = rnd_line();
            lines[i][3:0] = 4'(i);
            cyc(1'b1, lines[i], 1'b0, 1'b0);
        end
        check("fill_full", bus.full_out, 1);
        check("fill_count", bus.count_out, DEPTH);
        check("fill_overflow", bus.overflow_out, 0);
        cyc(1'b1, rnd_line(), 1'b0, 1'b0);
        check("drop_overflow", bus.overflow_out, 1);
        check("drop_count", bus.count_out, DEPTH);
        for (int i = 0; i < int'(DEPTH); i++) begin
            check("drain_a", bus.a_out, lanes(lines[i], 0));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("drain_empty", bus.empty_out, 1);

        // Clear the sticky overflow.
        rst_in = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst_in = 1'b0;
        check("ovf_cleared", bus.overflow_out, 0);

        // Push and pop together at full.
        for (int i = 0; i < int'(DEPTH); i++) begin
            lines[i] = rnd_line();
            lines[i][3:0] = 4'(i + 8);
            cyc(1'b1, lines[i], 1'b0, 1'b0);
        end
        new_line = rnd_line();
        new_line[3:0] = 4'hf;
        cyc(1'b1, new_line, 1'b1, 1'b0);
        check("full_pp_count", bus.count_out, DEPTH);
        check("full_pp_overflow", bus.overflow_out, 0);
        for (int i = 1; i < int'(DEPTH); i++) begin
            check("full_pp_a", bus.a_out, lanes(lines[i], 0));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("full_pp_new_a", bus.a_out, lanes(new_line, 0));
        check("full_pp_new_c", bus.c_out, lanes(new_line, 2));
        cyc(1'b0, '0, 1'b1, 1'b0);

        // Ten single-line push/pop pairs wrap both pointers.
        for (int i = 0; i < 10; i++) begin
            tmp_line = rnd_line();
            cyc(1'b1, tmp_line, 1'b0, 1'b0);
            check("wrap_b", bus.b_out, lanes(tmp_line, 1));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("wrap_empty", bus.empty_out, 1);

        // Flush beats a simultaneous push and pop.
        for (int i = 0; i < 3; i++) cyc(1'b1, rnd_line(), 1'b0, 1'b0);
        check("pre_flush_count", bus.count_out, 3);
        cyc(1'b1, rnd_line(), 1'b1, 1'b1);
        check("flush_count", bus.count_out, 0);
        check("flush_empty", bus.empty_out, 1);
        check("flush_valid", bus.fma_valid_out, 0);

        // Random traffic; the monitor scores every cycle.
        repeat (400) begin
            cyc($urandom_range(0, 9) < 6, rnd_line(), 1'($urandom_range(0, 1)),
                $urandom_range(0, 19) == 0);
        end

        // Async reset with two entries and overflow set.
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < int'(DEPTH) + 1; i++) cyc(1'b1, rnd_line(), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("pre_rst_count", bus.count_out, 2);
        check("pre_rst_overflow", bus.overflow_out, 1);
        bus.abc_valid_in = 1'b1;
        bus.abc_in       = rnd_line();
        bus.fma_ready_in = 1'b1;
        #1 rst_in = 1'b1;
        #1;
        check("async_rst_count", bus.count_out, 0);
        check("async_rst_valid", bus.fma_valid_out, 0);
        check("async_rst_empty", bus.empty_out, 1);
        check("async_rst_full", bus.full_out, 0);
        check("async_rst_overflow", bus.overflow_out, 0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        rst_in = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("end_empty", bus.empty_out, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
